// File: rtl/haar_pkg.sv
// Shared types and reference arithmetic for the integer Haar (S-transform)
// row and column passes. Default pixel width and the forward/inverse pair
// functions live here so every stage and checker agrees on the rounding.
package haar_pkg;

  // Default pixel width used by the typedefs and helper functions below.
  localparam int DEFAULT_DATA_W = 8;

  typedef logic [DEFAULT_DATA_W-1:0]      pixel_t;
  typedef logic signed [DEFAULT_DATA_W:0] detail_t;

  // Coefficient pair: approximation s and signed detail d.
  typedef struct packed {
    pixel_t  s;
    detail_t d;
  } coef_t;

  // Reconstructed pixel pair.
  typedef struct packed {
    pixel_t a;
    pixel_t b;
  } pair_t;

  // Row-stream FSM encoding: waiting for the first or second pixel of a pair.
  localparam logic [0:0] ST_FIRST  = 1'b0;
  localparam logic [0:0] ST_SECOND = 1'b1;

  // Forward lifting step: d = a - b, s = b + floor(d/2) == floor((a+b)/2).
  function automatic coef_t haar_fwd(input pixel_t a, input pixel_t b);
    coef_t   res;
    detail_t d;
    d     = $signed({1'b0, a}) - $signed({1'b0, b});
    res.d = d;
    res.s = pixel_t'($signed({1'b0, b}) + (d >>> 1));
    return res;
  endfunction

  // Inverse lifting step: b = s - floor(d/2), a = d + b.
  function automatic pair_t haar_inv(input pixel_t s, input detail_t d);
    pair_t   res;
    detail_t b_full;
    b_full = $signed({1'b0, s}) - (d >>> 1);
    res.b  = pixel_t'(b_full);
    res.a  = pixel_t'(d + b_full);
    return res;
  endfunction

endpackage

// File: rtl/haar_lift_pair.sv
// Combinational forward S-transform of one pixel pair (a, b) -> (s, d).
// Purely arithmetic so the column pass can reuse it unchanged.
module haar_lift_pair
  import haar_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic [DATA_W-1:0]      a,
  input  logic [DATA_W-1:0]      b,
  output logic [DATA_W-1:0]      s,
  output logic signed [DATA_W:0] d
);

  typedef logic [DATA_W-1:0] pix_t;

  // Detail is the exact difference; one extra bit keeps it lossless.
  assign d = $signed({1'b0, a}) - $signed({1'b0, b});

  // b + floor(d/2) always lands in [0, 2^DATA_W-1], so truncation is exact.
  assign s = pix_t'($signed({1'b0, b}) + (d >>> 1));

endmodule

// File: rtl/haar_row_stream.sv
// Streaming row pass of the integer Haar wavelet: pairs consecutive pixels,
// emits one (s, d) coefficient pair per pair with valid/ready on both sides,
// marks the last pair of each row and pulses row_done after it is taken.
// Optional feature: define HAAR_ZCOUNT_EN to add the zero_cnt output, which
// counts zero-detail pairs per row.
module haar_row_stream
  import haar_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int LENGTH = 256
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   abort,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_s,
  output logic signed [DATA_W:0] out_d,
  output logic                   out_last,
  output logic                   row_done
`ifdef HAAR_ZCOUNT_EN
  ,
  output logic [$clog2(LENGTH/2+1)-1:0] zero_cnt
`endif
);

  localparam int                CNT_W   = $clog2(LENGTH);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(LENGTH - 1);

  logic [0:0]              state_reg;
  logic [DATA_W-1:0]       a_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic                    out_valid_reg;
  logic [DATA_W-1:0]       s_reg;
  logic signed [DATA_W:0]  d_reg;
  logic                    last_reg;
  logic                    row_done_reg;

  logic                    in_fire;
  logic                    out_fire;
  logic                    pair_load;
  logic                    cnt_wrap;
  logic [DATA_W-1:0]       lift_s;
  logic signed [DATA_W:0]  lift_d;

  // Second pixel may only be taken when the output slot is free or draining.
  assign in_ready  = !abort && ((state_reg == ST_FIRST) || !out_valid_reg || out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid_reg && out_ready;
  assign pair_load = in_fire && (state_reg == ST_SECOND);
  assign cnt_wrap  = (cnt_reg == CNT_MAX);

  haar_lift_pair #(
    .DATA_W (DATA_W)
  ) u_lift (
    .a (a_reg),
    .b (in_data),
    .s (lift_s),
    .d (lift_d)
  );

  // Pair-phase FSM, first-pixel latch and per-row pixel counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= ST_FIRST;
      cnt_reg   <= '0;
      a_reg     <= '0;
    end else if (abort) begin
      state_reg <= ST_FIRST;
      cnt_reg   <= '0;
    end else if (in_fire) begin
      cnt_reg <= cnt_wrap ? '0 : cnt_reg + CNT_W'(1);
      if (state_reg == ST_FIRST) begin
        a_reg     <= in_data;
        state_reg <= ST_SECOND;
      end else begin
        state_reg <= ST_FIRST;
      end
    end
  end

  // Output register: loads a new pair, holds under backpressure, clears on accept.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid_reg <= 1'b0;
      s_reg         <= '0;
      d_reg         <= '0;
      last_reg      <= 1'b0;
      row_done_reg  <= 1'b0;
    end else if (abort) begin
      out_valid_reg <= 1'b0;
      last_reg      <= 1'b0;
      row_done_reg  <= 1'b0;
    end else begin
      row_done_reg <= out_fire && last_reg;
      if (pair_load) begin
        out_valid_reg <= 1'b1;
        s_reg         <= lift_s;
        d_reg         <= lift_d;
        last_reg      <= cnt_wrap;
      end else if (out_fire) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_s     = s_reg;
  assign out_d     = d_reg;
  assign out_last  = last_reg;
  assign row_done  = row_done_reg;

`ifdef HAAR_ZCOUNT_EN
  localparam int ZC_W = $clog2(LENGTH/2+1);

  logic [ZC_W-1:0] zc_reg;
  logic            restart_reg;

  // Zero-detail counter; after a row ends it holds until the next row's
  // first accepted pair, which restarts the count.
  always_ff @(posedge clk) begin
    if (!resetn || abort) begin
      zc_reg      <= '0;
      restart_reg <= 1'b0;
    end else if (out_fire) begin
      if (restart_reg) begin
        zc_reg <= ZC_W'(d_reg == '0);
      end else begin
        zc_reg <= zc_reg + ZC_W'(d_reg == '0);
      end
      restart_reg <= last_reg;
    end
  end

  assign zero_cnt = zc_reg;
`endif

endmodule

// File: doc/haar_row_stream.md
Name: haar_row_stream

Overview:
- Streaming, parametrised successor to the block-array row processor.
- Accepts one pixel per beat on a valid/ready input and pairs consecutive pixels (a, b).
- Emits one lossless integer-Haar (S-transform) coefficient pair (s, d) per input pair, with output backpressure and row framing.
- Sits between the image line source and the column pass / coefficient packer of the wavelet transformer.

Parameters:
- DATA_W, 8: pixel width in bits; s is DATA_W bits, d is DATA_W+1 bits signed.
- LENGTH, 256: pixels per row; must be even and at least 2; row counter width is $clog2(LENGTH).

Ports:
- clk  input  1  system clock
- resetn  input  1  synchronous active-low reset
- abort  input  1  synchronous row discard; drops the partial row and pending output
- in_valid  input  1  pixel valid
- in_ready  output  1  pixel accepted when in_valid && in_ready
- in_data  input  DATA_W  pixel, unsigned
- out_valid  output  1  coefficient pair valid
- out_ready  input  1  downstream accept
- out_s  output  DATA_W  approximation coefficient floor((a+b)/2)
- out_d  output  DATA_W+1  detail coefficient a-b, two's complement
- out_last  output  1  qualifies the final pair of a row (pair index LENGTH/2-1)
- row_done  output  1  one-cycle pulse when the last pair of a row is accepted downstream

Behaviour:
- Reset (resetn=0 at posedge clk):
  - out_valid=0, out_s=0, out_d=0, out_last=0, row_done=0.
  - Pixel counter=0; state=FIRST.
- FSM:
  - FIRST: in_ready=1 always. On handshake, latch in_data into reg a and go to SECOND.
  - SECOND: in_ready = !out_valid || out_ready. On handshake, take b=in_data.
    - Compute d = a - b (sign-extended to DATA_W+1) and s = b + (d >>> 1).
    - Register s, d and out_valid=1 on the next edge (latency 1 cycle from the b handshake).
    - Return to FIRST.
- Arithmetic: s always fits DATA_W with no saturation. Inverse is b = s - (d>>>1), a = d + b.
- Output hold: out_s, out_d and out_last stay stable while out_valid && !out_ready. out_valid clears on accept unless a new pair loads in the same cycle (back-to-back allowed).
- Throughput: one pair per 2 input beats at full rate; no bubbles when out_ready=1.
- Row framing:
  - Counter increments per accepted pixel and wraps to 0 after pixel LENGTH-1.
  - out_last=1 on the pair formed from pixels LENGTH-2 and LENGTH-1.
  - row_done pulses on the cycle after that pair's out handshake.
- abort:
  - Clears counter, state and out_valid.
  - Discards a latched a.
  - in_ready=0 during the abort cycle.
  - Has priority over simultaneous handshakes.
  - No row_done is generated.
- Reset mid-row is identical to abort, plus all outputs are cleared.
- in_valid may drop at any time. State is held and no beat is lost.

Optional Feature:
- Macro HAAR_ZCOUNT_EN.
- When defined:
  - Adds output zero_cnt, width $clog2(LENGTH/2+1).
  - Counts pairs in the current row with d==0, counted at out handshake.
  - Valid and stable from row_done until the next row's first out handshake, after which the count restarts.
  - abort and reset clear it to 0.
- When undefined: the port and logic are absent; all other behaviour is identical.

Decomposition:
- Package haar_pkg:
  - default DATA_W;
  - typedef for pixel (logic [DATA_W-1:0]) and detail (logic signed [DATA_W:0]);
  - function haar_fwd(a,b) returning the {s,d} struct;
  - function haar_inv for bench checking.
- Sub-module haar_lift_pair: combinational a,b -> s,d, reused later by the column pass.
- FSM, counter and output register stay in haar_row_stream.

Test Plan:
- Pairs (10,3), (3,10), (255,0), (0,255), (255,255) with out_ready=1 -> (s,d) = (6,7), (6,-7), (127,255), (127,-255), (255,0), each valid 1 cycle after b; haar_inv recovers a,b.
- LENGTH=8, continuous ramp 0..7 -> 4 pairs, each s=2k, d=-1; out_last only on the 4th pair; row_done pulses once the cycle after its accept.
- Hold out_ready=0 for 5 cycles with an output pending -> in_ready=0 in SECOND, out_s/out_d stable, no pixel lost; release -> stream continues in order.
- LENGTH=8: feed 3 pixels, assert abort, then feed a fresh row 20..27 -> first pair is (20,21) -> s=20, d=-1; no row_done from the aborted row.
- Assert resetn=0 mid-row with out_valid=1 -> next cycle out_valid=0, outputs 0; the following row is framed from pixel 0.
- HAAR_ZCOUNT_EN, LENGTH=8, pixels 5,5,7,7,1,2,9,9 -> zero_cnt=3 at row_done.
